// File: rtl/branch_predictor_pkg.sv
// Shared constants and counter encodings for the fetch-side branch target buffer.
package branch_predictor_pkg;

   localparam int BP_WORD_SIZE = 16;
   localparam int BP_IDX_BITS  = 8;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing signals of the branch predictor: IF prediction, ID/EX resolution, miss reporting.
interface branch_predictor_if
   import branch_predictor_pkg::*;
#(
   parameter int WORD_SIZE = BP_WORD_SIZE
);
   logic                 pred_taken_IF;
   logic [WORD_SIZE-1:0] pc_IF;
   logic [WORD_SIZE-1:0] pred_pc_IF;
   logic                 stall_IFID;
   logic                 jump_resolve_ID;
   logic [WORD_SIZE-1:0] pc_ID;
   logic [WORD_SIZE-1:0] jump_target_ID;
   logic                 pred_taken_ID;
   logic [WORD_SIZE-1:0] pred_pc_ID;
   logic                 branch_resolve_EX;
   logic [WORD_SIZE-1:0] pc_EX;
   logic                 branch_taken_EX;
   logic [WORD_SIZE-1:0] branch_target_EX;
   logic                 pred_taken_EX;
   logic [WORD_SIZE-1:0] pred_pc_EX;
   logic                 jump_miss;
   logic                 i_branch_miss;
   logic [WORD_SIZE-1:0] redirect_pc;
   logic [WORD_SIZE-1:0] miss_count;

   modport slave (
      input  pc_IF, stall_IFID,
      input  jump_resolve_ID, pc_ID, jump_target_ID, pred_taken_ID, pred_pc_ID,
      input  branch_resolve_EX, pc_EX, branch_taken_EX, branch_target_EX, pred_taken_EX, pred_pc_EX,
      output pred_taken_IF, pred_pc_IF, jump_miss, i_branch_miss, redirect_pc, miss_count
   );

   modport master (
      output pc_IF, stall_IFID,
      output jump_resolve_ID, pc_ID, jump_target_ID, pred_taken_ID, pred_pc_ID,
      output branch_resolve_EX, pc_EX, branch_taken_EX, branch_target_EX, pred_taken_EX, pred_pc_EX,
      input  pred_taken_IF, pred_pc_IF, jump_miss, i_branch_miss, redirect_pc, miss_count
   );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] i_cnt,
   input  logic       i_inc,
   output logic [1:0] o_next
);

   always_comb begin
      o_next = i_cnt;
      if (i_inc) begin
         if (i_cnt != ST) o_next = i_cnt + 2'd1;
      end else begin
         if (i_cnt != SNT) o_next = i_cnt - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts in IF, resolves jumps in ID and branches in EX.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         WORD_SIZE = BP_WORD_SIZE,
   parameter int         IDX_BITS  = BP_IDX_BITS,
   parameter bit         PREDICT   = 1'b1,
   parameter logic [1:0] CNT_INIT  = WNT
)
(
   input logic              clk,
   input logic              reset_n,
   branch_predictor_if.slave bp
);

   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = WORD_SIZE - IDX_BITS;

   logic                 r_valid  [ENTRIES];
   logic [TAG_W-1:0]     r_tag    [ENTRIES];
   logic [WORD_SIZE-1:0] r_target [ENTRIES];
   logic [1:0]           r_cnt    [ENTRIES];
   logic [WORD_SIZE-1:0] r_missCount;

   logic [IDX_BITS-1:0]  w_idxIF, w_idxID, w_idxEX;
   logic                 w_hitIF, w_hitEX;
   logic                 w_brMiss, w_jMiss;
   logic                 w_exWrite, w_idWrite;
   logic [1:0]           w_cntNext;
   logic [WORD_SIZE-1:0] w_pcIFInc, w_pcEXInc;

   assign w_idxIF   = bp.pc_IF[IDX_BITS-1:0];
   assign w_idxID   = bp.pc_ID[IDX_BITS-1:0];
   assign w_idxEX   = bp.pc_EX[IDX_BITS-1:0];
   assign w_pcIFInc = bp.pc_IF + WORD_SIZE'(1);
   assign w_pcEXInc = bp.pc_EX + WORD_SIZE'(1);

   assign w_hitIF = PREDICT & r_valid[w_idxIF] & (r_tag[w_idxIF] == bp.pc_IF[WORD_SIZE-1:IDX_BITS]);
   assign w_hitEX = r_valid[w_idxEX] & (r_tag[w_idxEX] == bp.pc_EX[WORD_SIZE-1:IDX_BITS]);

   assign bp.pred_taken_IF = w_hitIF & r_cnt[w_idxIF][1];
   assign bp.pred_pc_IF    = bp.pred_taken_IF ? r_target[w_idxIF] : w_pcIFInc;

   assign w_brMiss = bp.branch_resolve_EX &
                     ((bp.branch_taken_EX != bp.pred_taken_EX) |
                      (bp.branch_taken_EX & (bp.pred_pc_EX != bp.branch_target_EX)));
   assign w_jMiss  = bp.jump_resolve_ID & ~bp.stall_IFID &
                     (~bp.pred_taken_ID | (bp.pred_pc_ID != bp.jump_target_ID));

   // An older EX branch miss flushes the ID instruction, so its jump neither reports nor updates.
   assign bp.i_branch_miss = w_brMiss;
   assign bp.jump_miss     = w_jMiss & ~w_brMiss;
   assign bp.miss_count    = r_missCount;

   always_comb begin
      bp.redirect_pc = w_pcIFInc;
      if (w_brMiss)     bp.redirect_pc = bp.branch_taken_EX ? bp.branch_target_EX : w_pcEXInc;
      else if (w_jMiss) bp.redirect_pc = bp.jump_target_ID;
   end

   assign w_exWrite = PREDICT & bp.branch_resolve_EX & (w_hitEX | bp.branch_taken_EX);
   assign w_idWrite = PREDICT & bp.jump_resolve_ID & ~bp.stall_IFID & ~w_brMiss &
                      ~(w_exWrite & (w_idxEX == w_idxID));

   sat_counter2 u_satCounter (
      .i_cnt  (r_cnt[w_idxEX]),
      .i_inc  (bp.branch_taken_EX),
      .o_next (w_cntNext)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_INIT;
         end
      end else begin
         if (w_exWrite) begin
            if (w_hitEX) begin
               r_cnt[w_idxEX] <= w_cntNext;
               if (bp.branch_taken_EX) r_target[w_idxEX] <= bp.branch_target_EX;
            end else begin
               r_valid[w_idxEX]  <= 1'b1;
               r_tag[w_idxEX]    <= bp.pc_EX[WORD_SIZE-1:IDX_BITS];
               r_target[w_idxEX] <= bp.branch_target_EX;
               r_cnt[w_idxEX]    <= WT;
            end
         end
         if (w_idWrite) begin
            r_valid[w_idxID]  <= 1'b1;
            r_tag[w_idxID]    <= bp.pc_ID[WORD_SIZE-1:IDX_BITS];
            r_target[w_idxID] <= bp.jump_target_ID;
            r_cnt[w_idxID]    <= ST;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_missCount <= '0;
      else if ((bp.jump_miss | bp.i_branch_miss) && (r_missCount != '1))
         r_missCount <= r_missCount + WORD_SIZE'(1);
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: one predicting instance and one with prediction disabled, checked with immediate assertions.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   branch_predictor_if #(.WORD_SIZE(16)) ifA ();
   branch_predictor_if #(.WORD_SIZE(16)) ifB ();

   branch_predictor #(.WORD_SIZE(16), .IDX_BITS(8), .PREDICT(1'b1), .CNT_INIT(2'b01)) dutA (
      .clk     (clk),
      .reset_n (reset_n),
      .bp      (ifA)
   );

   branch_predictor #(.WORD_SIZE(16), .IDX_BITS(8), .PREDICT(1'b0), .CNT_INIT(2'b01)) dutB (
      .clk     (clk),
      .reset_n (reset_n),
      .bp      (ifB)
   );

   always #5 clk = ~clk;

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      #1;
   endtask

   task automatic clearInputs();
      ifA.pc_IF = 16'h0000;             ifB.pc_IF = 16'h0000;
      ifA.stall_IFID = 1'b0;            ifB.stall_IFID = 1'b0;
      ifA.jump_resolve_ID = 1'b0;       ifB.jump_resolve_ID = 1'b0;
      ifA.pc_ID = 16'h0000;             ifB.pc_ID = 16'h0000;
      ifA.jump_target_ID = 16'h0000;    ifB.jump_target_ID = 16'h0000;
      ifA.pred_taken_ID = 1'b0;         ifB.pred_taken_ID = 1'b0;
      ifA.pred_pc_ID = 16'h0000;        ifB.pred_pc_ID = 16'h0000;
      ifA.branch_resolve_EX = 1'b0;     ifB.branch_resolve_EX = 1'b0;
      ifA.pc_EX = 16'h0000;             ifB.pc_EX = 16'h0000;
      ifA.branch_taken_EX = 1'b0;       ifB.branch_taken_EX = 1'b0;
      ifA.branch_target_EX = 16'h0000;  ifB.branch_target_EX = 16'h0000;
      ifA.pred_taken_EX = 1'b0;         ifB.pred_taken_EX = 1'b0;
      ifA.pred_pc_EX = 16'h0000;        ifB.pred_pc_EX = 16'h0000;
   endtask

   task automatic setBranchA(input logic [15:0] pc, input logic taken, input logic [15:0] target,
                             input logic predT, input logic [15:0] predPc);
      ifA.branch_resolve_EX = 1'b1;
      ifA.pc_EX = pc;
      ifA.branch_taken_EX = taken;
      ifA.branch_target_EX = target;
      ifA.pred_taken_EX = predT;
      ifA.pred_pc_EX = predPc;
   endtask

   task automatic setJumpA(input logic [15:0] pc, input logic [15:0] target,
                           input logic predT, input logic [15:0] predPc, input logic stall);
      ifA.jump_resolve_ID = 1'b1;
      ifA.pc_ID = pc;
      ifA.jump_target_ID = target;
      ifA.pred_taken_ID = predT;
      ifA.pred_pc_ID = predPc;
      ifA.stall_IFID = stall;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      clearInputs();
      repeat (2) nextCycle();
      reset_n = 1'b1;

      // Cleared table predicts fall-through
      ifA.pc_IF = 16'h0040;
      applyStimulus();
      checkOutput("reset_pred_taken", 16'(ifA.pred_taken_IF), 16'h0000);
      checkOutput("reset_pred_pc", ifA.pred_pc_IF, 16'h0041);
      checkOutput("reset_miss_count", ifA.miss_count, 16'h0000);

      setJumpA(16'h0010, 16'h0080, 1'b0, 16'h0011, 1'b0);
      applyStimulus();
      checkOutput("jump_miss", 16'(ifA.jump_miss), 16'h0001);
      checkOutput("jump_redirect", ifA.redirect_pc, 16'h0080);
      checkOutput("jump_no_br_miss", 16'(ifA.i_branch_miss), 16'h0000);
      nextCycle();
      clearInputs();
      ifA.pc_IF = 16'h0010;
      applyStimulus();
      checkOutput("jump_learned_taken", 16'(ifA.pred_taken_IF), 16'h0001);
      checkOutput("jump_learned_pc", ifA.pred_pc_IF, 16'h0080);
      checkOutput("jump_miss_count", ifA.miss_count, 16'h0001);

      // Branch at 0x0020: allocate taken, then walk the counter down and back up
      setBranchA(16'h0020, 1'b1, 16'h0005, 1'b0, 16'h0021);
      applyStimulus();
      checkOutput("br_alloc_miss", 16'(ifA.i_branch_miss), 16'h0001);
      checkOutput("br_alloc_redirect", ifA.redirect_pc, 16'h0005);
      nextCycle();
      clearInputs();
      ifA.pc_IF = 16'h0020;
      applyStimulus();
      checkOutput("br_cnt10_taken", 16'(ifA.pred_taken_IF), 16'h0001);
      checkOutput("br_cnt10_pc", ifA.pred_pc_IF, 16'h0005);
      checkOutput("br_miss_count2", ifA.miss_count, 16'h0002);

      setBranchA(16'h0020, 1'b0, 16'h0005, 1'b1, 16'h0005);
      applyStimulus();
      checkOutput("br_nt_miss", 16'(ifA.i_branch_miss), 16'h0001);
      checkOutput("br_nt_redirect", ifA.redirect_pc, 16'h0021);
      nextCycle();
      applyStimulus();
      checkOutput("br_cnt01_taken", 16'(ifA.pred_taken_IF), 16'h0000);
      checkOutput("br_cnt01_pc", ifA.pred_pc_IF, 16'h0021);
      setBranchA(16'h0020, 1'b0, 16'h0005, 1'b0, 16'h0021);
      applyStimulus();
      checkOutput("br_nt_correct", 16'(ifA.i_branch_miss), 16'h0000);
      nextCycle();
      nextCycle();
      applyStimulus();
      checkOutput("br_cnt00_taken", 16'(ifA.pred_taken_IF), 16'h0000);
      checkOutput("br_cnt00_miss_count", ifA.miss_count, 16'h0003);

      // From a saturated 00 one taken lands on 01 (still not taken), a second on 10 with a new target
      setBranchA(16'h0020, 1'b1, 16'h0005, 1'b0, 16'h0021);
      nextCycle();
      applyStimulus();
      checkOutput("br_sat_low_taken", 16'(ifA.pred_taken_IF), 16'h0000);
      setBranchA(16'h0020, 1'b1, 16'h0007, 1'b0, 16'h0021);
      applyStimulus();
      checkOutput("br_retarget_redirect", ifA.redirect_pc, 16'h0007);
      nextCycle();
      clearInputs();
      ifA.pc_IF = 16'h0020;
      applyStimulus();
      checkOutput("br_retarget_taken", 16'(ifA.pred_taken_IF), 16'h0001);
      checkOutput("br_retarget_pc", ifA.pred_pc_IF, 16'h0007);
      checkOutput("br_miss_count5", ifA.miss_count, 16'h0005);

      setBranchA(16'h0020, 1'b1, 16'h0009, 1'b1, 16'h0007);
      applyStimulus();
      checkOutput("br_wrong_target_miss", 16'(ifA.i_branch_miss), 16'h0001);
      checkOutput("br_wrong_target_redirect", ifA.redirect_pc, 16'h0009);
      nextCycle();
      clearInputs();
      ifA.pc_IF = 16'h0020;
      applyStimulus();
      checkOutput("br_new_target_pc", ifA.pred_pc_IF, 16'h0009);

      // EX miss and ID jump miss aliasing index 0x30 in the same cycle
      setBranchA(16'h0130, 1'b1, 16'h0200, 1'b0, 16'h0131);
      setJumpA(16'h0230, 16'h0300, 1'b0, 16'h0231, 1'b0);
      applyStimulus();
      checkOutput("both_br_miss", 16'(ifA.i_branch_miss), 16'h0001);
      checkOutput("both_jump_suppressed", 16'(ifA.jump_miss), 16'h0000);
      checkOutput("both_redirect", ifA.redirect_pc, 16'h0200);
      nextCycle();
      clearInputs();
      ifA.pc_IF = 16'h0130;
      applyStimulus();
      checkOutput("both_ex_entry_pc", ifA.pred_pc_IF, 16'h0200);
      checkOutput("both_miss_count", ifA.miss_count, 16'h0007);
      ifA.pc_IF = 16'h0230;
      applyStimulus();
      checkOutput("both_id_dropped", 16'(ifA.pred_taken_IF), 16'h0000);

      // Stalled jump is ignored until the stall drops
      ifA.pc_IF = 16'h0050;
      setJumpA(16'h0050, 16'h0090, 1'b0, 16'h0051, 1'b1);
      applyStimulus();
      checkOutput("stall_no_miss", 16'(ifA.jump_miss), 16'h0000);
      nextCycle();
      applyStimulus();
      checkOutput("stall_no_write", 16'(ifA.pred_taken_IF), 16'h0000);
      checkOutput("stall_miss_count", ifA.miss_count, 16'h0007);
      ifA.stall_IFID = 1'b0;
      applyStimulus();
      checkOutput("unstall_miss", 16'(ifA.jump_miss), 16'h0001);
      checkOutput("unstall_redirect", ifA.redirect_pc, 16'h0090);
      nextCycle();
      setJumpA(16'h0050, 16'h0090, 1'b1, 16'h0090, 1'b0);
      applyStimulus();
      checkOutput("jump_correct_no_miss", 16'(ifA.jump_miss), 16'h0000);
      checkOutput("jump_learned_0050", ifA.pred_pc_IF, 16'h0090);
      checkOutput("unstall_miss_count", ifA.miss_count, 16'h0008);

      // Reset with a pending jump update discards it and clears everything
      setJumpA(16'h0060, 16'h00A0, 1'b0, 16'h0061, 1'b0);
      reset_n = 1'b0;
      nextCycle();
      reset_n = 1'b1;
      clearInputs();
      ifA.pc_IF = 16'h0060;
      applyStimulus();
      checkOutput("rst_mid_pred_taken", 16'(ifA.pred_taken_IF), 16'h0000);
      checkOutput("rst_mid_pred_pc", ifA.pred_pc_IF, 16'h0061);
      checkOutput("rst_mid_miss_count", ifA.miss_count, 16'h0000);
      ifA.pc_IF = 16'h0130;
      applyStimulus();
      checkOutput("rst_mid_table_clear", 16'(ifA.pred_taken_IF), 16'h0000);

      // Prediction disabled: taken branch misses every time, fall-through always predicted
      ifB.branch_resolve_EX = 1'b1;
      ifB.pc_EX = 16'h0020;
      ifB.branch_taken_EX = 1'b1;
      ifB.branch_target_EX = 16'h0005;
      ifB.pred_taken_EX = 1'b0;
      ifB.pred_pc_EX = 16'h0021;
      ifB.pc_IF = 16'h0020;
      applyStimulus();
      checkOutput("nopred_miss1", 16'(ifB.i_branch_miss), 16'h0001);
      nextCycle();
      applyStimulus();
      checkOutput("nopred_taken", 16'(ifB.pred_taken_IF), 16'h0000);
      checkOutput("nopred_pc", ifB.pred_pc_IF, 16'h0021);
      checkOutput("nopred_miss2", 16'(ifB.i_branch_miss), 16'h0001);
      nextCycle();
      ifB.branch_resolve_EX = 1'b0;
      ifB.pc_IF = 16'hFFFF;
      applyStimulus();
      checkOutput("nopred_wrap_pc", ifB.pred_pc_IF, 16'h0000);
      checkOutput("nopred_wrap_taken", 16'(ifB.pred_taken_IF), 16'h0000);
      checkOutput("nopred_miss_count", ifB.miss_count, 16'h0002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch target buffer with 2-bit saturating direction counters.
- Predicts next PC in IF and resolves predictions against actual outcomes: jumps in ID, conditional branches in EX.
- Generates jump_miss, i_branch_miss and a redirect PC. These are the miss inputs consumed by the hazard control unit, which turns them into flush/pc_write controls.
- Sits beside the PC register in the IF stage.

Parameters:
WORD_SIZE, 16, PC/data width
IDX_BITS, 8, BTB index width (2^IDX_BITS entries, direct mapped)
PREDICT, 1, 1 = BTB prediction enabled; 0 = always predict PC+1, table never written
CNT_INIT, 2'b01, counter value loaded on reset (weakly not-taken)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
pc_IF  input  WORD_SIZE  PC of the instruction being fetched
pred_taken_IF  output  1  prediction: taken
pred_pc_IF  output  WORD_SIZE  predicted next PC (target if taken, else pc_IF+1)
stall_IFID  input  1  hazard unit stall; when 1, ID resolution is ignored
jump_resolve_ID  input  1  valid unconditional jump (JMP/JAL/JPR/JRL) in ID
pc_ID  input  WORD_SIZE  PC of ID instruction
jump_target_ID  input  WORD_SIZE  actual jump target
pred_taken_ID  input  1  prediction carried with ID instruction
pred_pc_ID  input  WORD_SIZE  predicted next PC carried with ID instruction
branch_resolve_EX  input  1  valid conditional branch (BNE/BEQ/BGZ/BLZ) in EX
pc_EX  input  WORD_SIZE  PC of EX instruction
branch_taken_EX  input  1  actual branch outcome
branch_target_EX  input  WORD_SIZE  actual branch target
pred_taken_EX  input  1  prediction carried with EX instruction
pred_pc_EX  input  WORD_SIZE  predicted next PC carried with EX instruction
jump_miss  output  1  ID jump mispredicted
i_branch_miss  output  1  EX branch mispredicted
redirect_pc  output  WORD_SIZE  correct next PC when either miss is 1
miss_count  output  WORD_SIZE  saturating count of misses (perf)

Behaviour:
Storage:
- Per entry: valid, tag = pc[WORD_SIZE-1:IDX_BITS], target, cnt[1:0].
- Index = pc[IDX_BITS-1:0].
- Table is registers; reads are combinational.

Prediction (combinational, zero latency):
- hit = PREDICT & valid & tag match.
- pred_taken_IF = hit & cnt[1].
- pred_pc_IF = pred_taken_IF ? target : pc_IF+1 (mod 2^WORD_SIZE; 16'hFFFF+1 wraps to 0).

Branch resolution (combinational):
- br_miss = branch_resolve_EX & ((branch_taken_EX != pred_taken_EX) | (branch_taken_EX & pred_pc_EX != branch_target_EX)).
- i_branch_miss = br_miss.

Jump resolution (combinational):
- j_miss = jump_resolve_ID & !stall_IFID & (!pred_taken_ID | pred_pc_ID != jump_target_ID).
- jump_miss = j_miss & !br_miss. The ID instruction is flushed by the older branch miss.

Redirect:
- br_miss: branch_taken_EX ? branch_target_EX : pc_EX+1.
- Else j_miss: jump_target_ID.
- Else pc_IF+1 (don't-care).

Updates (next rising edge, only if PREDICT=1):
- Branch resolve, entry hit: cnt saturating ±1 (taken: min(cnt+1,3); not taken: max(cnt-1,0)); target <= branch_target_EX when taken.
- Branch resolve, entry miss: allocate only if taken (valid=1, tag, target, cnt=2'b10). Not-taken miss allocates nothing.
- Jump resolve (qualified by !stall_IFID and !br_miss): write valid=1, tag, target=jump_target_ID, cnt=2'b11. This overwrites any alias.
- Same-cycle EX and ID writes to the same index: EX write wins, ID write dropped.
- miss_count increments by 1 per cycle with jump_miss|i_branch_miss, saturating at all-ones. Both misses in the same cycle count once.

Reset:
- reset_n=0 at an edge: all valid<=0, cnt<=CNT_INIT, target/tag<=0, miss_count<=0.
- Reset wins over any same-cycle update.
- Reset mid-operation discards the pending update.
- Combinational outputs during reset follow the cleared table from the next cycle: pred_taken_IF=0, pred_pc_IF=pc_IF+1.

Decomposition:
- constants.v: WORD_SIZE, counter encodings (SNT=00, WNT=01, WT=10, ST=11).
- Sub-module sat_counter2: next-state function for a 2-bit saturating counter (inc/dec), instantiated for the update path.

Test Plan:
- After reset, pc_IF=16'h0040 -> pred_taken_IF=0, pred_pc_IF=16'h0041; miss_count=0.
- Jump in ID: pc_ID=16'h0010, target 16'h0080, pred_taken_ID=0 -> jump_miss=1, redirect_pc=16'h0080. Next cycle pc_IF=16'h0010 -> pred_taken_IF=1, pred_pc_IF=16'h0080.
- Branch at 16'h0020, target 16'h0005, taken, unpredicted -> i_branch_miss=1, redirect 16'h0005, cnt=10. Not taken twice -> cnt 01 then 00, predict not-taken. Third not-taken stays at 00.
- Same cycle: EX branch miss plus ID jump miss at same index -> i_branch_miss=1, jump_miss=0, redirect=branch outcome, only EX entry written, miss_count +1.
- stall_IFID=1 with mispredicted jump in ID -> jump_miss=0, no table write. Stall released next cycle -> jump_miss=1.
- PREDICT=0: taken branch -> i_branch_miss=1 every occurrence, pred_taken_IF always 0. Also check pc_IF=16'hFFFF -> pred_pc_IF=16'h0000.
